audio_i2s_tx: RTL
=================

Name: audio_i2s_tx

Overview:
Final audio output stage. Takes the mixed signed left/right samples (PCM path after volume, sign-extended to 24 bits by the mixer) and serialises them as a standard I2S stream for the external DAC. It is the master timing source for the audio path. It emits a one-clk next_sample strobe per frame, which drives the pcm block's sample-rate accumulator and FIFO fetch.

Parameters:
BCK_HALF, 4, clk cycles per BCK half-period; legal values 1..255; 25 MHz clk gives 512 clk/frame, fs = 48828 Hz
SAMPLE_W, 24, bits per channel word transmitted, MSB first; legal values 1..31
SLOT_W, 32, BCK periods per channel slot (fixed, frame = 2*SLOT_W = 64 BCK)

Ports:
rst  in  1  asynchronous reset, active-high
clk  in  1  system clock
left_audio  in  SAMPLE_W  signed left sample; sampled only at frame start
right_audio  in  SAMPLE_W  signed right sample; sampled only at frame start
next_sample  out  1  one-clk pulse at each frame start; coincides with shadow latch
i2s_bck  out  1  bit clock
i2s_lrck  out  1  word select: 0 = left slot, 1 = right slot
i2s_data  out  1  serial data; changes only on BCK falling edge

Behaviour:
- Reset is asynchronous, active-high, on rst; clock is clk. All state is registered.
- Reset values: div=0, bck=0, bit counter b=63, lrck=1, data=0, next_sample=0, left_sh=0, right_sh=0.
- Divider: div counts 0..BCK_HALF-1. When div==BCK_HALF-1, div wraps to 0 and bck toggles. BCK period = 2*BCK_HALF clk.
- On a falling-edge event (bck 1->0 in the same cycle), b increments modulo 64. All of lrck/data/next_sample update in that same cycle.
- Frame start is the b 63->0 transition:
  - left_sh<=left_audio and right_sh<=right_audio, both in the same clk.
  - next_sample=1 for exactly that clk, 0 otherwise.
- First next_sample after reset release occurs at clk edge 2*BCK_HALF. Pulses then repeat every 128*BCK_HALF clk.
- lrck = b[5] (registered alongside b), so lrck changes on a BCK falling edge, as I2S requires.
- Slot position s = b[4:0]; word w = b[5] ? right_sh : left_sh.
  - For 1 <= s <= SAMPLE_W: data = w[SAMPLE_W - s], i.e. MSB one BCK after the lrck edge.
  - For s = 0 or s > SAMPLE_W: data = 0.
- Latency: input value present at frame-start clk appears on i2s_data starting 1 BCK later. The right channel is delayed a further 32 BCK.
- Input changes between frame starts have no effect on the frame in progress. The pcm output update triggered by next_sample lands in the next frame.
- BCK_HALF=1: bck toggles every clk. Falling events occur every 2nd clk. Same rules apply.
- Reset mid-frame: outputs return to reset values immediately, with no partial word completed. The sequence restarts as after power-up.
- next_sample is never asserted while rst is high.

Decomposition:
- Shared audio package holds:
  - AUDIO_SAMPLE_W = 24
  - I2S_SLOT_W = 32
  - I2S_FRAME_BCK = 64
  - default BCK_HALF for 25 MHz
- One natural sub-module: i2s_bck_gen (div counter, bck register, falling-edge strobe output). The frame counter, shadows and shifter remain in audio_i2s_tx.

Test Plan:
- Reset: hold rst 5 clk -> bck=0, lrck=1, data=0, next_sample=0. After release, first next_sample at clk 8 (BCK_HALF=4), next at clk 520, spacing 512.
- Word format: left_audio=0x800001, right_audio=0x7FFFFE held -> DAC-model capture on BCK rising edges.
  - Left slot bits 1..24 = 0x800001; right slot bits 1..24 = 0x7FFFFE.
  - Slot bits 0 and 25..31 = 0; lrck falls and rises on BCK falling edges.
- Sample hold: change left_audio from 0x123456 to 0x654321 mid-left-slot -> current frame still sends 0x123456; next frame sends 0x654321.
- pcm handshake: connect pcm with sample_rate=128 and FIFO preloaded with 8-bit mono values 0x10, 0x20 at volume 15.
  - Valid I2S words appear on alternate frames.
  - Each word equals sign-extended 0x10<<8*128, then 0x20<<8*128.
- Reset mid-right-slot: assert rst at b=40 -> outputs at reset values within the same clk. After release, timing is identical to the power-up case.
- Parameter corner: BCK_HALF=1, SAMPLE_W=16 -> frame = 128 clk. Bits 1..16 carry the word; bits 17..31 = 0.

Source files
------------

// File: rtl/audio_i2s_tx_pkg.sv
// Shared audio constants and I2S slot helpers for the output stage.
package audio_i2s_tx_pkg;

  localparam int unsigned AUDIO_SAMPLE_W     = 24;
  localparam int unsigned I2S_SLOT_W         = 32;
  localparam int unsigned I2S_FRAME_BCK      = 64;
  localparam int unsigned I2S_BCK_HALF_25MHZ = 4;

  localparam int unsigned I2S_BIT_CNT_W = $clog2(I2S_FRAME_BCK);
  localparam int unsigned SLOT_POS_W    = $clog2(I2S_SLOT_W);

  typedef logic [I2S_BIT_CNT_W-1:0] i2s_bit_cnt_t;
  typedef logic [SLOT_POS_W-1:0]    i2s_slot_pos_t;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } i2s_chan_e;

  // Serial bit at slot position pos: MSB one BCK after the word-select edge,
  // zero at position 0 and after the last sample bit.
  function automatic logic i2s_slot_bit(input logic [I2S_SLOT_W-1:0] word,
                                        input i2s_slot_pos_t         pos,
                                        input int unsigned           sample_w);
    i2s_slot_pos_t idx;
    idx = SLOT_POS_W'(sample_w) - pos;
    if ((32'(pos) >= 32'd1) && (32'(pos) <= sample_w)) begin
      return word[idx];
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/audio_i2s_tx_if.sv
// Sample hand-off between the mixer and the I2S transmitter.
interface audio_i2s_tx_if
  import audio_i2s_tx_pkg::*;
#(
  parameter int unsigned SAMPLE_W = AUDIO_SAMPLE_W
);

  logic signed [SAMPLE_W-1:0] left_audio;
  logic signed [SAMPLE_W-1:0] right_audio;
  logic                       next_sample;

  modport master (
    output left_audio,
    output right_audio,
    input  next_sample
  );

  modport slave (
    input  left_audio,
    input  right_audio,
    output next_sample
  );

endinterface

// File: rtl/audio_i2s_tx_bck_gen.sv
// I2S bit-clock divider: bck toggles every BCK_HALF clk; fall marks the clk
// in which the registered bck goes 1 -> 0.
module i2s_bck_gen
  import audio_i2s_tx_pkg::*;
#(
  parameter int unsigned BCK_HALF = I2S_BCK_HALF_25MHZ
) (
  input  logic clk,
  input  logic rst,
  output logic bck,
  output logic fall
);

  localparam int unsigned      DIV_W    = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_HALF - 1);

  logic [DIV_W-1:0] div;
  logic             wrap;

  assign wrap = (div == DIV_LAST);
  assign fall = wrap & bck;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
      bck <= 1'b0;
    end else if (wrap) begin
      div <= '0;
      bck <= ~bck;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S master transmitter: 64-BCK frames, left then right slot, samples
// shadowed at frame start and announced with a one-clk next_sample strobe.
module audio_i2s_tx
  import audio_i2s_tx_pkg::*;
#(
  parameter int unsigned BCK_HALF = I2S_BCK_HALF_25MHZ,
  parameter int unsigned SAMPLE_W = AUDIO_SAMPLE_W
) (
  input  logic           clk,
  input  logic           rst,
  audio_i2s_tx_if.slave  aud,
  output logic           i2s_bck,
  output logic           i2s_lrck,
  output logic           i2s_data
);

  logic                  bck_fall;
  i2s_bit_cnt_t          b;
  i2s_bit_cnt_t          b_next;
  logic                  frame_start;
  i2s_chan_e             chan_next;
  logic [I2S_SLOT_W-1:0] word_ext;
  logic                  data_next;
  logic [SAMPLE_W-1:0]   left_sh;
  logic [SAMPLE_W-1:0]   right_sh;

  i2s_bck_gen #(
    .BCK_HALF(BCK_HALF)
  ) u_bck_gen (
    .clk  (clk),
    .rst  (rst),
    .bck  (i2s_bck),
    .fall (bck_fall)
  );

  always_comb begin
    b_next      = b + i2s_bit_cnt_t'(1);
    frame_start = bck_fall && (b == '1);
    chan_next   = i2s_chan_e'(b_next[I2S_BIT_CNT_W-1]);
    // Shadows are read before this clk's latch, which is safe: slot position 0 always sends 0.
    if (chan_next == CH_RIGHT) begin
      word_ext = {{(I2S_SLOT_W-SAMPLE_W){1'b0}}, right_sh};
    end else begin
      word_ext = {{(I2S_SLOT_W-SAMPLE_W){1'b0}}, left_sh};
    end
    data_next = i2s_slot_bit(word_ext, b_next[SLOT_POS_W-1:0], SAMPLE_W);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b               <= '1;
      i2s_lrck        <= 1'b1;
      i2s_data        <= 1'b0;
      aud.next_sample <= 1'b0;
      left_sh         <= '0;
      right_sh        <= '0;
    end else begin
      aud.next_sample <= frame_start;
      if (bck_fall) begin
        b        <= b_next;
        i2s_lrck <= (chan_next == CH_RIGHT);
        i2s_data <= data_next;
      end
      if (frame_start) begin
        left_sh  <= aud.left_audio;
        right_sh <= aud.right_audio;
      end
    end
  end

endmodule
